// File: rtl/magic_packet_checker.sv
// magic_packet_checker
//   Data-integrity checker that runs beside an arbitrated FIFO. It picks one
//   pushed word (the "magic packet"), latches its data, and counts the entries
//   queued ahead of it. When that word reaches the head and is popped, the
//   FIFO output is compared with the latched copy. Any mismatch, or any
//   inconsistency between the count and the FIFO flags, clears the sticky
//   prop_ok bit.
//
//   Optional feature (compile-time macro MPC_REARM_EN):
//     defined   - after DONE the checker returns to IDLE, reloads cnt from a
//                 shadow occupancy counter and may capture a new packet.
//     undefined - DONE is terminal until reset and no shadow counter is built.
module magic_packet_checker #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              full,
    input  logic              empty,
    input  logic [WIDTH-1:0]  push_data,
    input  logic [WIDTH-1:0]  pop_data,
    input  logic              capture_req,
    output logic              captured,
    output logic [CNTWID-1:0] cnt,
    output logic [WIDTH-1:0]  magic_data,
    output logic              done,
    output logic              prop_ok,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [CNTWID-1:0] CNT_MAX = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] CNT_ONE = CNTWID'(1);

    state_t            state_q, state_d;
    logic [CNTWID-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  magic_q, magic_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;

    // Only flag-qualified requests change anything; a push into a full FIFO
    // or a pop from an empty one is a no-op for the FIFO and for us.
    logic push_acc;
    logic pop_acc;

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

`ifdef MPC_REARM_EN
    // True FIFO occupancy, kept regardless of state so a re-armed capture
    // starts from the real count rather than the frozen post-exit value.
    logic [CNTWID-1:0] occ_q, occ_d;

    // Next shadow occupancy, saturating at 0 and DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (push_acc && !pop_acc && occ_q != CNT_MAX) begin
            occ_d = occ_q + CNT_ONE;
        end else if (pop_acc && !push_acc && occ_q != '0) begin
            occ_d = occ_q - CNT_ONE;
        end
    end

    // Shadow occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end
`endif

    // Next-state and next-output logic for the tracking FSM.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        magic_d = magic_q;
        done_d  = 1'b0;
        ok_d    = ok_q;

        case (state_q)
            ST_IDLE: begin
                // Popping while our occupancy says zero means the count and
                // the FIFO's empty flag disagree.
                if (pop_acc && cnt_q == '0) begin
                    ok_d = 1'b0;
                end

                if (capture_req && push_acc) begin
                    // The captured word itself is not counted; only a
                    // same-cycle pop of an older entry moves the count.
                    state_d = ST_TRACK;
                    magic_d = push_data;
                    if (pop_acc && cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else if (push_acc && !pop_acc) begin
                    if (cnt_q == CNT_MAX) begin
                        ok_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (pop_acc && !push_acc && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_TRACK: begin
                // Pushes land behind the magic packet and never matter here.
                if (pop_acc) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        // The magic packet is leaving the FIFO now.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        if (pop_data != magic_q) begin
                            ok_d = 1'b0;
                        end
                    end
                end
            end

            ST_DONE: begin
`ifdef MPC_REARM_EN
                state_d = ST_IDLE;
                cnt_d   = occ_d;
`else
                state_d = ST_DONE;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any comparison in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            magic_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            magic_q <= magic_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    assign captured   = (state_q != ST_IDLE);
    assign cnt        = cnt_q;
    assign magic_data = magic_q;
    assign done       = done_q;
    assign prop_ok    = ok_q;
    assign state      = state_q;

endmodule

// File: doc/magic_packet_checker.md
Name: magic_packet_checker

Overview:
- Data-integrity checker that sits beside the arbitrated FIFO, next to the magic-packet tracker.
- Selects one pushed word (the "magic packet"), latches its data, and counts how many entries sit ahead of it.
- When that packet reaches the head and is popped, compares the FIFO's output data against the latched copy.
- Drives the capture qualifier consumed by the tracker and exposes a single property bit for formal/simulation assertion.

Parameters:
- WIDTH, 8, data word width
- DEPTH, 8, FIFO depth in entries
- CNTWID, $clog2(DEPTH)+1, width of the ahead-count (holds 0..DEPTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- push  input  1  FIFO push request
- pop  input  1  FIFO pop request
- full  input  1  FIFO full flag
- empty  input  1  FIFO empty flag
- push_data  input  WIDTH  data written on push
- pop_data  input  WIDTH  data at FIFO head (valid with pop & ~empty)
- capture_req  input  1  free/nondeterministic request to choose the current push as magic
- captured  output  1  high from the cycle after capture until reset (or re-arm)
- cnt  output  CNTWID  entries ahead of magic packet (pre-capture: FIFO occupancy)
- magic_data  output  WIDTH  latched magic-packet data
- done  output  1  one-cycle pulse, registered, after the magic packet is popped
- prop_ok  output  1  0 after a data mismatch or count protocol error; sticky until reset
- state  output  2  FSM state: 00 IDLE, 01 TRACK, 10 DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, magic_data=0, done=0, prop_ok=1, captured=0.
- Qualified events: push_acc = push & ~full; pop_acc = pop & ~empty. Unqualified push/pop leave all state untouched.
- IDLE:
  - cnt tracks occupancy: cnt += push_acc, cnt -= pop_acc; both asserted means no change.
  - If capture_req & push_acc: latch magic_data=push_data, next state=TRACK, next cnt = cnt - pop_acc (captured word is not counted).
- TRACK:
  - push_acc is ignored for the count.
  - pop_acc with cnt!=0: cnt -= 1.
  - pop_acc with cnt==0: the magic packet exits. Compare pop_data to magic_data; on inequality, prop_ok<=0. Next state=DONE, done<=1 for one cycle.
  - capture_req is ignored.
- DONE: cnt holds, done<=0 after the first cycle. Terminal unless MPC_REARM_EN is defined.
- captured = (state != IDLE), derived from the registered state with no extra latency.
- Error checks, each sets prop_ok<=0:
  - cnt would exceed DEPTH.
  - pop_acc in IDLE with cnt==0 (occupancy mismatch against empty).
  - In both cases cnt saturates at 0 / DEPTH and does not wrap.
- Simultaneous capture and pop of an older entry is legal; cnt reflects only the pop.
- Capture into an empty FIFO with cnt==0 gives the magic packet at the head; the next pop_acc completes it.
- Latency: magic_data is valid the cycle after capture; done and prop_ok update the cycle after the exit pop.
- Reset mid-TRACK: returns to IDLE immediately; the comparison is abandoned and prop_ok returns to 1.

Optional Feature:
- MPC_REARM_EN defined:
  - DONE returns to IDLE on the next cycle and captured drops.
  - cnt is reloaded with the true occupancy, kept in a second shadow counter that is always maintained.
  - A new capture is then permitted. prop_ok stays sticky across captures.
- MPC_REARM_EN undefined: DONE holds until reset; the shadow counter is not built.

Test Plan:
- Reset, 3 pushes (0x11, 0x22, 0x33), then push 0x44 with capture_req -> state=TRACK, cnt=3, magic_data=0x44; 4 pops with pop_data in order -> done pulses after 4th pop, prop_ok=1.
- Same as above but 4th pop_data=0x45 -> done pulses, prop_ok=0 and stays 0.
- Empty FIFO, push 0xA5 with capture_req, and pop in the same cycle with empty=1 -> pop ignored, cnt=0; next pop with pop_data=0xA5 -> done=1, prop_ok=1.
- TRACK with cnt=2; push_acc and pop_acc together for 2 cycles -> cnt goes 2,1,0; further pushes do not change cnt.
- DEPTH=8 full, push asserted with full=1 and capture_req -> no capture, cnt stays 8, state=IDLE.
- rst_n low mid-TRACK with cnt=5 -> state=IDLE, cnt=0, captured=0 asynchronously. With MPC_REARM_EN: after done, state returns to IDLE in 1 cycle and a second capture succeeds.
